// File: rtl/run_sequencer.sv
// run_sequencer
//
// Steps the single-cycle core through up to NUM_PROG programs in one
// sequence. For each enabled slot it asks the host for a data-memory
// preload, holds the core in reset for RST_CYC cycles with the slot's
// start PC applied, releases it and counts cycles until the core reports
// done or the run counter hits its all-ones limit. Each run is reported
// with a one-cycle run_valid pulse; all_done pulses once after the last
// enabled slot.
//
// Ports:
//   clk, reset          clock and asynchronous active-low reset
//   go, prog_mask       sequence start and enabled-slot mask (sampled in IDLE)
//   start_pc            per-slot start PC, slot i at [i*PC_W +: PC_W]
//   load_req, load_ack  preload handshake with the host
//   core_reset          registered active-high reset to the core
//   core_start_pc       PC the core loads while held in reset
//   core_done           core completion flag, honoured only while running
//   busy, cur_prog      sequence in progress / slot being serviced
//   run_valid           one-cycle pulse with run_prog/run_cycles/run_timeout
//   all_done            one-cycle pulse at sequence end
module run_sequencer #(
  parameter int NUM_PROG = 3,
  parameter int PC_W     = 10,
  parameter int CNT_W    = 16,
  parameter int RST_CYC  = 2,
  localparam int PROG_W  = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go,
  input  logic [NUM_PROG-1:0]      prog_mask,
  input  logic [NUM_PROG*PC_W-1:0] start_pc,
  output logic                     load_req,
  input  logic                     load_ack,
  output logic                     core_reset,
  output logic [PC_W-1:0]          core_start_pc,
  input  logic                     core_done,
  output logic                     busy,
  output logic [PROG_W-1:0]        cur_prog,
  output logic                     run_valid,
  output logic [PROG_W-1:0]        run_prog,
  output logic [CNT_W-1:0]         run_cycles,
  output logic                     run_timeout,
  output logic                     all_done
);

  localparam int HOLD_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    REPORT,
    FINISH
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [NUM_PROG-1:0] mask_q;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [CNT_W-1:0]    run_cnt;
  logic [PROG_W-1:0]   first_slot;
  logic [PROG_W-1:0]   next_slot;
  logic                has_next;
  logic [PC_W-1:0]     first_pc;
  logic [PC_W-1:0]     next_pc;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Slot search: lowest set bit of the incoming mask, and the next set bit
  // of the latched mask above the slot currently being serviced. Loops run
  // high-to-low so the last hit is the lowest qualifying slot.
  always_comb begin
    first_slot = '0;
    for (int i = NUM_PROG - 1; i >= 0; i--) begin
      if (prog_mask[i]) begin
        first_slot = PROG_W'(i);
      end
    end
    has_next  = 1'b0;
    next_slot = '0;
    for (int i = NUM_PROG - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(cur_prog))) begin
        has_next  = 1'b1;
        next_slot = PROG_W'(i);
      end
    end
    first_pc = start_pc[int'(first_slot)*PC_W +: PC_W];
    next_pc  = start_pc[int'(next_slot)*PC_W +: PC_W];
  end

  // Next-state logic. core_done wins over the limit because it is tested
  // in the same condition and the datapath checks it first.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (go) begin
          next_state = (prog_mask != '0) ? LOAD : FINISH;
        end
      end
      LOAD: begin
        if (load_ack) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (core_done || (run_cnt == CNT_MAX)) begin
          next_state = REPORT;
        end
      end
      REPORT: begin
        next_state = has_next ? LOAD : FINISH;
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath. core_reset is registered from next_state so it changes on
  // the same edge as the state and never glitches; it is low only in RUN.
  // The run counter is preset to 1 while holding so the first RUN cycle
  // reads 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_reset    <= 1'b1;
      mask_q        <= '0;
      cur_prog      <= '0;
      core_start_pc <= '0;
      hold_cnt      <= '0;
      run_cnt       <= '0;
      run_prog      <= '0;
      run_cycles    <= '0;
      run_timeout   <= 1'b0;
    end else begin
      core_reset <= (next_state != RUN);
      case (state)
        IDLE: begin
          if (go && (prog_mask != '0)) begin
            mask_q        <= prog_mask;
            cur_prog      <= first_slot;
            core_start_pc <= first_pc;
          end
        end
        LOAD: begin
          hold_cnt <= '0;
        end
        HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          run_cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
        end
        RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (core_done) begin
            run_prog    <= cur_prog;
            run_cycles  <= run_cnt;
            run_timeout <= 1'b0;
          end else if (run_cnt == CNT_MAX) begin
            run_prog    <= cur_prog;
            run_cycles  <= CNT_MAX;
            run_timeout <= 1'b1;
          end
        end
        REPORT: begin
          if (has_next) begin
            cur_prog      <= next_slot;
            core_start_pc <= next_pc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs decode directly from the state register
  always_comb begin
    load_req  = (state == LOAD);
    busy      = (state == LOAD) || (state == HOLD) || (state == RUN) || (state == REPORT);
    run_valid = (state == REPORT);
    all_done  = (state == FINISH);
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer
//
// Drives two run_sequencer instances (16-bit and 8-bit run counters) from a
// host/core model that answers preload requests and raises core_done after
// a configured number of running cycles. Expected reports are computed from
// the per-slot configuration alone.
module tb_run_sequencer;

  typedef struct {
    int prog;
    int cycles;
    bit tmo;
  } rep_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        load_ack;
  logic        core_done;
  logic [2:0]  prog_mask;
  logic [29:0] start_pc;
  logic        sel8;
  logic        go_a;
  logic        go_b;

  logic        a_load_req, a_core_reset, a_busy, a_run_valid, a_run_timeout, a_all_done;
  logic [9:0]  a_pc;
  logic [1:0]  a_cur, a_run_prog;
  logic [15:0] a_cycles;

  logic        b_load_req, b_core_reset, b_busy, b_run_valid, b_run_timeout, b_all_done;
  logic [9:0]  b_pc;
  logic [1:0]  b_cur, b_run_prog;
  logic [7:0]  b_cycles;

  logic        o_load_req, o_core_reset, o_busy, o_run_valid, o_run_timeout, o_all_done;
  logic [9:0]  o_pc;
  logic [1:0]  o_cur, o_run_prog;
  logic [15:0] o_cycles;

  int vectors = 0;
  int miscompares = 0;
  int cfg_done[3];
  int cfg_ack[3];
  bit noise;

  assign go_a = go & ~sel8;
  assign go_b = go & sel8;

  assign o_load_req    = sel8 ? b_load_req    : a_load_req;
  assign o_core_reset  = sel8 ? b_core_reset  : a_core_reset;
  assign o_busy        = sel8 ? b_busy        : a_busy;
  assign o_run_valid   = sel8 ? b_run_valid   : a_run_valid;
  assign o_run_timeout = sel8 ? b_run_timeout : a_run_timeout;
  assign o_all_done    = sel8 ? b_all_done    : a_all_done;
  assign o_pc          = sel8 ? b_pc          : a_pc;
  assign o_cur         = sel8 ? b_cur         : a_cur;
  assign o_run_prog    = sel8 ? b_run_prog    : a_run_prog;
  assign o_cycles      = sel8 ? {8'h00, b_cycles} : a_cycles;

  always #5 clk = ~clk;

  run_sequencer #(.NUM_PROG(3), .PC_W(10), .CNT_W(16), .RST_CYC(2)) dut (
    .clk(clk), .reset(reset), .go(go_a), .prog_mask(prog_mask), .start_pc(start_pc),
    .load_req(a_load_req), .load_ack(load_ack), .core_reset(a_core_reset),
    .core_start_pc(a_pc), .core_done(core_done), .busy(a_busy), .cur_prog(a_cur),
    .run_valid(a_run_valid), .run_prog(a_run_prog), .run_cycles(a_cycles),
    .run_timeout(a_run_timeout), .all_done(a_all_done)
  );

  run_sequencer #(.NUM_PROG(3), .PC_W(10), .CNT_W(8), .RST_CYC(2)) dut8 (
    .clk(clk), .reset(reset), .go(go_b), .prog_mask(prog_mask), .start_pc(start_pc),
    .load_req(b_load_req), .load_ack(load_ack), .core_reset(b_core_reset),
    .core_start_pc(b_pc), .core_done(core_done), .busy(b_busy), .cur_prog(b_cur),
    .run_valid(b_run_valid), .run_prog(b_run_prog), .run_cycles(b_cycles),
    .run_timeout(b_run_timeout), .all_done(b_all_done)
  );

  // Runs one full sequence on the selected instance while acting as host
  // and core, then compares the observed reports, preload PCs and
  // handshake timing against what the slot configuration implies.
  task automatic run_seq(input logic [2:0] mask, input int budget);
    rep_t exp_q[$];
    rep_t got_q[$];
    int pc_q[$];
    rep_t r;
    int limit, cyc, loads, run_cnt, ack_wait, hold_len;
    bit done_seen, prev_req, prev_valid, saw_run;
    logic [29:0] spc;
    limit = sel8 ? 255 : 65535;
    spc = start_pc;
    cyc = 0; loads = 0; run_cnt = 0; ack_wait = 0; hold_len = 0;
    done_seen = 0; prev_req = 0; prev_valid = 0; saw_run = 0;
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        r.prog = i;
        if (cfg_done[i] == 0 || cfg_done[i] > limit) begin
          r.cycles = limit; r.tmo = 1'b1;
        end else begin
          r.cycles = cfg_done[i]; r.tmo = 1'b0;
        end
        exp_q.push_back(r);
      end
    end
    @(negedge clk);
    prog_mask = mask; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    vectors++;
    if (mask != 3'b000) begin
      if (o_load_req !== 1'b1 || o_busy !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL go_to_load: load_req=%b busy=%b, required 1 1", o_load_req, o_busy);
      end
    end else if (o_all_done !== 1'b1 || o_load_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL empty_mask_finish: all_done=%b load_req=%b, required 1 0", o_all_done, o_load_req);
    end
    while (!done_seen && cyc < budget) begin
      if (prev_valid) begin
        vectors++;
        if (!(o_load_req === 1'b1 || o_all_done === 1'b1)) begin
          miscompares++;
          $display("[TB] FAIL report_followup: load_req=%b all_done=%b, required one of them 1", o_load_req, o_all_done);
        end
      end
      if (o_run_valid === 1'b1) begin
        r.prog = int'(o_run_prog); r.cycles = int'(o_cycles); r.tmo = o_run_timeout;
        got_q.push_back(r);
      end
      if (o_load_req && !prev_req) begin
        loads++;
        pc_q.push_back(int'(o_pc));
      end
      if (o_core_reset === 1'b0) begin
        if (run_cnt == 0) begin
          vectors++;
          if (hold_len != 2) begin
            miscompares++;
            $display("[TB] FAIL hold_length: %0d reset cycles after ack, required 2", hold_len);
          end
        end
        run_cnt++;
        saw_run = 1;
      end else begin
        run_cnt = 0;
      end
      if (o_load_req) hold_len = 0;
      else if (o_core_reset && o_busy) hold_len++;
      if (o_all_done === 1'b1) begin
        done_seen = 1;
        vectors++;
        if (o_busy !== 1'b0 || o_core_reset !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL finish_outputs: busy=%b core_reset=%b, required 0 1", o_busy, o_core_reset);
        end
      end
      prev_req = o_load_req;
      prev_valid = o_run_valid;
      load_ack = 1'b0; core_done = 1'b0; go = 1'b0;
      if (o_load_req) begin
        ack_wait++;
        if (ack_wait > cfg_ack[o_cur]) load_ack = 1'b1;
      end else begin
        ack_wait = 0;
      end
      if (!o_core_reset && run_cnt == cfg_done[o_cur]) core_done = 1'b1;
      if (noise) begin
        if (o_busy && o_core_reset) core_done = 1'($urandom_range(0, 1));
        if (!o_load_req) load_ack = 1'($urandom_range(0, 1));
        if (o_busy && $urandom_range(0, 3) == 0) begin
          go = 1'b1; prog_mask = 3'($urandom);
        end
      end
      cyc++;
      @(negedge clk);
    end
    go = 1'b0; load_ack = 1'b0; core_done = 1'b0;
    vectors++;
    if (!done_seen) begin
      miscompares++;
      $display("[TB] FAIL sequence_budget: no all_done within %0d cycles, required all_done", budget);
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("[TB] FAIL report_count: %0d reports, required %0d", got_q.size(), exp_q.size());
    end
    vectors++;
    if (loads != $countones(mask)) begin
      miscompares++;
      $display("[TB] FAIL load_count: %0d preload requests, required %0d", loads, $countones(mask));
    end
    vectors++;
    if (saw_run != (mask != 3'b000)) begin
      miscompares++;
      $display("[TB] FAIL core_release: core released=%0d, required %0d", saw_run, mask != 3'b000);
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < got_q.size()) begin
        vectors++;
        if (got_q[k].prog != exp_q[k].prog || got_q[k].cycles != exp_q[k].cycles || got_q[k].tmo != exp_q[k].tmo) begin
          miscompares++;
          $display("[TB] FAIL report_%0d: got (%0d,%0d,%0d), required (%0d,%0d,%0d)", k,
                   got_q[k].prog, got_q[k].cycles, got_q[k].tmo, exp_q[k].prog, exp_q[k].cycles, exp_q[k].tmo);
        end
      end
      if (k < pc_q.size()) begin
        vectors++;
        if (pc_q[k] != int'(spc[exp_q[k].prog*10 +: 10])) begin
          miscompares++;
          $display("[TB] FAIL start_pc_%0d: got %0d, required %0d", k, pc_q[k], spc[exp_q[k].prog*10 +: 10]);
        end
      end
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (o_all_done !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_all_done: all_done=%b busy=%b after sequence, required 0 0", o_all_done, o_busy);
    end
  endtask

  // Reset values of both instances while reset is held
  task automatic test_reset();
    logic [35:0] obs, req;
    reset = 1'b0; go = 1'b0; load_ack = 1'b0; core_done = 1'b0;
    prog_mask = 3'b000; start_pc = '0; sel8 = 1'b0; noise = 1'b0;
    repeat (3) @(negedge clk);
    req = {1'b0, 1'b1, 4'b0000, 2'b00, 2'b00, 10'd0, 16'd0};
    for (int s = 0; s < 2; s++) begin
      sel8 = 1'(s);
      #1;
      obs = {o_load_req, o_core_reset, o_busy, o_run_valid, o_run_timeout, o_all_done,
             o_cur, o_run_prog, o_pc, o_cycles};
      vectors++;
      if (obs !== req) begin
        miscompares++;
        $display("[TB] FAIL reset_values_%0d: got %h, required %h", s, obs, req);
      end
    end
    sel8 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Three slots, one-cycle preload latency
  task automatic test_full_sequence();
    sel8 = 1'b0; noise = 1'b0;
    start_pc = {10'd30, 10'd12, 10'd0};
    cfg_done = '{50, 200, 900};
    cfg_ack = '{1, 1, 1};
    run_seq(3'b111, 3000);
  endtask

  // Middle slot disabled
  task automatic test_skip_slot();
    sel8 = 1'b0; noise = 1'b0;
    start_pc = {10'd700, 10'd345, 10'd5};
    cfg_done = '{9, 33, 4};
    cfg_ack = '{0, 2, 3};
    run_seq(3'b101, 1000);
  endtask

  // Asynchronous reset in the 40th running cycle of slot 1, then a clean restart
  task automatic test_reset_mid_run();
    logic [35:0] obs, req;
    int rc, cyc;
    sel8 = 1'b0; noise = 1'b0;
    start_pc = {10'd111, 10'd222, 10'd333};
    @(negedge clk);
    prog_mask = 3'b010; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    rc = 0; cyc = 0;
    while (rc < 40 && cyc < 500) begin
      load_ack = o_load_req;
      if (!o_core_reset) rc++;
      cyc++;
      if (rc < 40) @(negedge clk);
    end
    load_ack = 1'b0;
    vectors++;
    if (rc != 40) begin
      miscompares++;
      $display("[TB] FAIL mid_run_reach: %0d running cycles, required 40", rc);
    end
    #2 reset = 1'b0;
    #1;
    obs = {o_load_req, o_core_reset, o_busy, o_run_valid, o_run_timeout, o_all_done,
           o_cur, o_run_prog, o_pc, o_cycles};
    req = {1'b0, 1'b1, 4'b0000, 2'b00, 2'b00, 10'd0, 16'd0};
    vectors++;
    if (obs !== req) begin
      miscompares++;
      $display("[TB] FAIL mid_run_reset: got %h, required %h", obs, req);
    end
    @(negedge clk);
    reset = 1'b1;
    cfg_done = '{0, 40, 0};
    cfg_ack = '{0, 0, 0};
    run_seq(3'b010, 500);
  endtask

  // 8-bit counter: slot 0 never finishes and must time out at 255
  task automatic test_timeout();
    sel8 = 1'b1; noise = 1'b0;
    start_pc = {10'd3, 10'd2, 10'd1};
    cfg_done = '{0, 17, 0};
    cfg_ack = '{0, 2, 0};
    run_seq(3'b011, 1000);
    sel8 = 1'b0;
  endtask

  // Empty mask goes straight to the completion pulse
  task automatic test_empty_mask();
    sel8 = 1'b0; noise = 1'b0;
    cfg_done = '{5, 5, 5};
    cfg_ack = '{0, 0, 0};
    run_seq(3'b000, 20);
  endtask

  // Spurious handshakes and go pulses while busy; done exactly on the limit
  task automatic test_noise_limit();
    sel8 = 1'b1; noise = 1'b1;
    start_pc = {10'd1000, 10'd500, 10'd250};
    cfg_done = '{255, 0, 254};
    cfg_ack = '{2, 0, 1};
    run_seq(3'b101, 1500);
    sel8 = 1'b0; noise = 1'b0;
  endtask

  // Randomized masks, PCs, run lengths and preload latencies
  task automatic test_random();
    sel8 = 1'b0;
    for (int it = 0; it < 5; it++) begin
      noise = 1'($urandom_range(0, 1));
      start_pc = 30'($urandom);
      for (int i = 0; i < 3; i++) begin
        cfg_done[i] = $urandom_range(1, 400);
        cfg_ack[i] = $urandom_range(0, 3);
      end
      run_seq(3'($urandom_range(1, 7)), 3000);
    end
    noise = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_sequence();
    test_reset_mid_run();
    test_skip_slot();
    test_timeout();
    test_empty_mask();
    test_noise_limit();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Top-level run controller for the single-cycle core. It steps the core through up to NUM_PROG programs in a single sequence: multiply, pattern search, closest pair. For each enabled program it requests a data-memory preload from the host, holds the core in reset, releases it at that program's start PC, and waits for the core's `done`. Each run's cycle count and timeout status are reported, and a single completion pulse fires after the last enabled program.

## Interface
- NUM_PROG, 3, number of program slots.
- PC_W, 10, start-PC width.
- CNT_W, 16, run-cycle counter width; timeout limit is 2^CNT_W-1 cycles.
- RST_CYC, 2, cycles the core reset is held after each preload (≥1).

- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- go  in  1  start-sequence pulse; sampled only in IDLE.
- prog_mask  in  NUM_PROG  enabled programs; sampled with go.
- start_pc  in  NUM_PROG*PC_W  start PC per slot; slot i at [i*PC_W +: PC_W].
- load_req  out  1  preload request for slot cur_prog.
- load_ack  in  1  host has finished the preload.
- core_reset  out  1  active-high reset to the core.
- core_start_pc  out  PC_W  PC the core loads while core_reset=1.
- core_done  in  1  core `done`; honoured only in RUN.
- busy  out  1  sequence in progress.
- cur_prog  out  $clog2(NUM_PROG)  slot being serviced.
- run_valid  out  1  one-cycle pulse when run results are valid.
- run_prog  out  $clog2(NUM_PROG)  slot of the reported run.
- run_cycles  out  CNT_W  cycles spent in RUN.
- run_timeout  out  1  reported run hit the limit.
- all_done  out  1  one-cycle pulse at sequence end.

## Operation
- States: IDLE, LOAD, HOLD, RUN, REPORT, FINISH.
- Reset (any time, including mid-run): state=IDLE. Outputs: core_reset=1, load_req=0, busy=0, run_valid=0, all_done=0, cur_prog=0, run_prog=0, run_cycles=0, run_timeout=0, core_start_pc=0, counters=0.
- IDLE: core_reset=1.
  - go=1 with prog_mask≠0: latch mask; cur_prog = lowest set bit; go to LOAD.
  - go=1 with prog_mask=0: go to FINISH.
  - go is ignored in every other state; the latched mask is immune to later prog_mask changes.
- LOAD: load_req=1 and busy=1. core_start_pc = start_pc slot cur_prog, held through REPORT. Stay until load_ack=1 at an edge, then go to HOLD. load_ack outside LOAD is ignored.
- HOLD: core_reset=1 for exactly RST_CYC cycles, then go to RUN.
- RUN: core_reset=0.
  - Counter is 1 in the first RUN cycle and increments each cycle.
  - core_done=1 at an edge: go to REPORT; run_cycles = current count; run_timeout=0.
  - Count reaching 2^CNT_W-1 without done: go to REPORT; run_cycles = 2^CNT_W-1; run_timeout=1.
  - Done and the limit on the same edge: done wins (run_timeout=0).
- REPORT (one cycle): core_reset=1, run_valid=1, run_prog=cur_prog. Next:
  - Next set mask bit above cur_prog exists: cur_prog = that bit; go to LOAD.
  - Otherwise: go to FINISH.
- FINISH (one cycle): all_done=1, busy=0; return to IDLE. run_* registers keep the last report until the next one or reset.
- core_reset is 0 only in RUN; it is registered and glitch-free.

## Timing
- go at edge t: load_req=1 and busy=1 from t+1.
- load_ack at edge t: load_req=0 at t+1; core_reset=1 for t+1 … t+RST_CYC; core_reset=0 from t+RST_CYC+1 (count=1).
- core_done at the edge where count=N: run_valid=1 and run_cycles=N in the following cycle. The next load_req (or all_done) follows one cycle after that.
- The core always sees at least RST_CYC+1 cycles of reset between runs (HOLD plus REPORT).
- load_ack may arrive in the first LOAD cycle: minimum LOAD duration is 1 cycle.

## Test plan
- Reset mid-RUN (slot 1, count=40): all outputs return to reset values asynchronously. The next go with mask=3'b010 restarts slot 1 cleanly with count=1.
- mask=3'b111, start_pc={30,12,0}, load_ack 1 cycle after each load_req, core_done at counts 50/200/900 → three run_valid pulses: (0,50,0), (1,200,0), (2,900,0). core_start_pc values 0, 12, 30. A single all_done follows; busy drops with it.
- mask=3'b101 → slot 1 skipped. run_prog sequence 0, 2; load_req asserted exactly twice.
- CNT_W=8, core_done never asserted → run_cycles=255, run_timeout=1, then the sequence continues to the next slot.
- go with mask=0 → all_done the next cycle, load_req never asserted, core_reset stays 1.
- core_done and load_ack toggled during LOAD/HOLD, and go pulsed while busy → no state effect. core_done exactly on the limit edge → run_timeout=0.
